// File: rtl/spi_reg_ctrl_if.sv
// SPI byte-level handshake between an SPI slave shifter and spi_reg_ctrl.
`default_nettype none

interface spi_reg_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             sel_;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_byte;
  logic [WIDTH-1:0] tx_byte;

  modport master (output sel_, output rx_valid, output rx_byte, input  tx_byte);
  modport slave  (input  sel_, input  rx_valid, input  rx_byte, output tx_byte);
endinterface

`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
// SPI command decoder driving seven read/write registers plus a read-only status word.
`default_nettype none

module spi_reg_ctrl #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] ID    = 8'hA5
) (
  input  logic               clk,
  input  logic               reset_,
  spi_reg_ctrl_if.slave      spi,
  input  logic [WIDTH-1:0]   status_in,
  output logic [7*WIDTH-1:0] reg_q,
  output logic               wr_stb,
  output logic [2:0]         wr_addr,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_WDATA = 2'd2,
    S_RDATA = 2'd3
  } state_t;

  state_t                  state_q,   state_d;
  logic [2:0]              addr_q,    addr_d;
  logic                    inc_q,     inc_d;
  logic [WIDTH-1:0]        tx_q,      tx_d;
  logic [6:0][WIDTH-1:0]   regs_q,    regs_d;
  logic                    wr_stb_q,  wr_stb_d;
  logic [2:0]              wr_addr_q, wr_addr_d;
  logic                    rd_pend_q, rd_pend_d;
  logic                    sel_hi_q;

  logic                  w_rx;
  logic [2:0]            w_addr_nxt;
  logic [7:0][WIDTH-1:0] w_words;

  assign w_rx       = spi.rx_valid && !spi.sel_;
  assign w_addr_nxt = inc_q ? addr_q + 3'd1 : addr_q;
  // Address 7 reads the live status input rather than a stored register.
  assign w_words    = {status_in, regs_q};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    inc_d     = inc_q;
    tx_d      = tx_q;
    regs_d    = regs_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    rd_pend_d = 1'b0;

    if (spi.sel_) begin
      state_d = S_IDLE;
      tx_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Only a fresh high-to-low edge of sel_ opens a transaction.
          if (sel_hi_q) begin
            state_d = S_CMD;
            tx_d    = ID;
          end
        end
        S_CMD: begin
          if (w_rx) begin
            addr_d = spi.rx_byte[2:0];
            inc_d  = spi.rx_byte[6];
            if (spi.rx_byte[7]) begin
              state_d   = S_RDATA;
              rd_pend_d = 1'b1;
            end else begin
              state_d = S_WDATA;
              tx_d    = '0;
            end
          end
        end
        S_WDATA: begin
          tx_d = '0;
          if (w_rx) begin
            if (addr_q != 3'd7) begin
              regs_d[addr_q] = spi.rx_byte;
              wr_stb_d       = 1'b1;
              wr_addr_d      = addr_q;
            end
            addr_d = w_addr_nxt;
          end
        end
        S_RDATA: begin
          if (w_rx) begin
            addr_d = w_addr_nxt;
            tx_d   = w_words[w_addr_nxt];
          end else if (rd_pend_q) begin
            tx_d = w_words[addr_q];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      inc_q     <= 1'b0;
      tx_q      <= '0;
      regs_q    <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      rd_pend_q <= 1'b0;
      sel_hi_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      inc_q     <= inc_d;
      tx_q      <= tx_d;
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      rd_pend_q <= rd_pend_d;
      sel_hi_q  <= spi.sel_;
    end
  end

  assign spi.tx_byte = tx_q;
  assign reg_q       = regs_q;
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
// Randomised transaction bench for spi_reg_ctrl with a transaction-level register model.
`default_nettype none

module tb_spi_reg_ctrl;

  localparam logic [7:0] C_ID = 8'hA5;

  logic        clk;
  logic        reset_;
  logic [7:0]  status_in;
  logic [55:0] reg_q;
  logic        wr_stb;
  logic [2:0]  wr_addr;
  logic        busy;

  spi_reg_ctrl_if #(.WIDTH(8)) spi ();

  spi_reg_ctrl #(.WIDTH(8), .ID(C_ID)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .spi       (spi),
    .status_in (status_in),
    .reg_q     (reg_q),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_bad = 0;
  logic [7:0] mdl_regs [8];
  logic [7:0] txq [$];
  logic [7:0] tx_seen [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] word(input logic [2:0] a);
    return (a == 3'd7) ? status_in : mdl_regs[a];
  endfunction

  function automatic logic [55:0] mdl_q();
    logic [55:0] r;
    for (int i = 0; i < 7; i++) r[i*8 +: 8] = mdl_regs[i];
    return r;
  endfunction

  // Runs one sel_-framed transaction from txq; byte 0 is the command.
  task automatic do_txn(input bit sel_with_last);
    int         n;
    bit         rd, inc, aborted;
    logic [2:0] base, a;
    n       = txq.size();
    rd      = 1'b0;
    inc     = 1'b0;
    base    = 3'd0;
    aborted = 1'b0;
    tx_seen.delete();
    spi.sel_ = 1'b0;
    spi.rx_valid = 1'b0;
    step();
    chk("busy_start", busy, 1);
    chk("tx_id", spi.tx_byte, C_ID);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) begin
        spi.rx_byte = 8'($urandom);
        step();
        chk("gap_stb", wr_stb, 0);
        chk("gap_busy", busy, 1);
      end
      if (k == n - 1 && sel_with_last) begin
        spi.sel_     = 1'b1;
        spi.rx_valid = 1'b1;
        spi.rx_byte  = txq[k];
        step();
        spi.rx_valid = 1'b0;
        chk("abort_stb", wr_stb, 0);
        aborted = 1'b1;
        break;
      end
      spi.rx_valid = 1'b1;
      spi.rx_byte  = txq[k];
      step();
      spi.rx_valid = 1'b0;
      spi.rx_byte  = 8'($urandom);
      if (k == 0) begin
        rd   = txq[0][7];
        inc  = txq[0][6];
        base = txq[0][2:0];
        if (rd) begin
          step();
          chk("rd_first", spi.tx_byte, word(base));
          tx_seen.push_back(spi.tx_byte);
        end else begin
          chk("wr_tx0", spi.tx_byte, 0);
        end
      end else if (rd) begin
        a = inc ? base + 3'(k) : base;
        chk("rd_next", spi.tx_byte, word(a));
        tx_seen.push_back(spi.tx_byte);
      end else begin
        a = inc ? base + 3'(k - 1) : base;
        chk("wr_stb", wr_stb, (a != 3'd7));
        if (a != 3'd7) begin
          chk("wr_addr", wr_addr, a);
          mdl_regs[a] = txq[k];
        end
        chk("wr_tx", spi.tx_byte, 0);
      end
    end
    if (!aborted) begin
      spi.sel_ = 1'b1;
      step();
    end
    chk("busy_end", busy, 0);
    chk("tx_idle", spi.tx_byte, 0);
    chk("regs", reg_q, mdl_q());
    step();
    step();
  endtask

  initial begin
    logic [55:0] snap;
    int          n;
    for (int i = 0; i < 8; i++) mdl_regs[i] = 8'h00;
    reset_       = 1'b0;
    spi.sel_     = 1'b1;
    spi.rx_valid = 1'b0;
    spi.rx_byte  = 8'h00;
    status_in    = 8'h00;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_tx", spi.tx_byte, 0);
    chk("rst_regs", reg_q, 0);
    chk("rst_stb", wr_stb, 0);
    chk("rst_waddr", wr_addr, 0);
    reset_ = 1'b1;
    repeat (2) step();

    // Write with auto-increment starting at reg2.
    txq = '{8'h42, 8'h11, 8'h22, 8'h33};
    do_txn(1'b0);
    chk("w_reg2", reg_q[23:16], 8'h11);
    chk("w_reg3", reg_q[31:24], 8'h22);
    chk("w_reg4", reg_q[39:32], 8'h33);

    // Preload reg6/reg0 across the 6->7->0 wrap; address 7 write discarded.
    txq = '{8'h46, 8'h66, 8'hAA, 8'h10};
    do_txn(1'b0);
    status_in = 8'h5C;
    txq = '{8'hC6, 8'h00, 8'h00};
    do_txn(1'b0);
    chk("rd_wrap0", tx_seen[0], 8'h66);
    chk("rd_wrap1", tx_seen[1], 8'h5C);
    chk("rd_wrap2", tx_seen[2], 8'h10);

    snap = reg_q;
    txq = '{8'h07, 8'hFF};
    do_txn(1'b0);
    chk("a7_regs", reg_q, snap);

    // Abort after command only, then a read must decode its first byte as command.
    txq = '{8'h41};
    do_txn(1'b0);
    chk("abort_reg1", reg_q[15:8], snap[15:8]);
    txq = '{8'h81, 8'h00};
    do_txn(1'b0);
    chk("after_abort", tx_seen[0], mdl_regs[1]);

    // Final byte arrives on the same edge sel_ rises.
    txq = '{8'h43, 8'h5A, 8'h77};
    do_txn(1'b1);
    chk("selrise_reg4", reg_q[39:32], 8'h33);

    for (int t = 0; t < 40; t++) begin
      status_in = 8'($urandom);
      n = $urandom_range(1, 6);
      txq.delete();
      for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
      do_txn($urandom_range(0, 7) == 0);
    end

    // Asynchronous reset mid-write, then no start while sel_ is held low.
    spi.sel_ = 1'b0;
    step();
    spi.rx_valid = 1'b1;
    spi.rx_byte  = 8'h40;
    step();
    spi.rx_byte  = 8'hEE;
    step();
    spi.rx_valid = 1'b0;
    #1 reset_ = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_regs", reg_q, 0);
    chk("arst_stb", wr_stb, 0);
    chk("arst_waddr", wr_addr, 0);
    chk("arst_tx", spi.tx_byte, 0);
    for (int i = 0; i < 8; i++) mdl_regs[i] = 8'h00;
    step();
    reset_ = 1'b1;
    repeat (3) step();
    chk("no_start_low", busy, 0);
    spi.sel_ = 1'b1;
    repeat (2) step();
    txq = '{8'h45, 8'h3C};
    do_txn(1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: SPI word width in bits; fixed at 8 for this block.
REQ-002 SHALL have parameter ID, default 8'hA5: byte shifted out during the command byte.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port sel_, input, 1: SPI chip select, active low, already synchronised to clk; frames a transaction.
REQ-006 SHALL have port rx_valid, input, 1: one-cycle strobe from the SPI slave when a full byte is received.
REQ-007 SHALL have port rx_byte, input, 8: received byte; valid only while rx_valid=1.
REQ-008 SHALL have port tx_byte, output, 8: parallel word handed to the SPI slave for the next byte shifted out.
REQ-009 SHALL have port status_in, input, 8: read-only status value, visible at address 7.
REQ-010 SHALL have port reg_q, output, 56: registers 0..6 concatenated, reg0 in bits [7:0].
REQ-011 SHALL have port wr_stb, output, 1: one-cycle pulse on each accepted register write.
REQ-012 SHALL have port wr_addr, output, 3: address of the write flagged by wr_stb.
REQ-013 SHALL have port busy, output, 1: high while a transaction is in progress (state not IDLE).

Function
REQ-014 SHALL implement states IDLE, CMD, WDATA and RDATA.
REQ-015 SHALL ignore rx_valid whenever sel_=1, including a cycle where rx_valid=1 and sel_ rises together.
REQ-016 SHALL move from any state to IDLE in the cycle after sel_=1 is sampled; a partial transaction is abandoned and no write occurs for it.
REQ-017 SHALL move IDLE->CMD when sel_=0 is sampled, and load tx_byte<=ID in the same edge.
REQ-018 SHALL decode the first byte in CMD as: bit7 R/W (1=read), bit6 auto-increment, bits[2:0] address; bits[5:3] are ignored.
REQ-019 SHALL, on a CMD byte, latch the address and inc flag, then go to RDATA (read) or WDATA (write).
REQ-020 SHALL, on a read CMD byte, load tx_byte with the word at the address exactly one clk later: reg[addr] for addresses 0-6, or status_in sampled at that edge for address 7.
REQ-021 SHALL, for each rx_valid in RDATA, advance the address if inc=1 (modulo 8, 7->0) and load tx_byte with the word at the new address on the same edge; received data is discarded.
REQ-022 SHALL, for each rx_valid in WDATA with address 0-6, write rx_byte to reg[addr] on that edge and assert wr_stb=1 with wr_addr=addr for exactly the next cycle.
REQ-023 SHALL discard writes to address 7: no register change and no wr_stb; auto-increment still applies.
REQ-024 SHALL, for each rx_valid in WDATA, advance the address if inc=1 (modulo 8); tx_byte SHALL be 8'h00 throughout WDATA.
REQ-025 SHALL, when inc=0, keep repeating the same address for every data byte.
REQ-026 SHALL allow an unlimited number of data bytes per transaction.
REQ-027 SHALL hold tx_byte at 8'h00 in IDLE.

Reset
REQ-028 SHALL, while reset_=0, hold state=IDLE, reg_q=0, tx_byte=8'h00, wr_stb=0, wr_addr=0, busy=0, and address/inc latches =0.
REQ-029 SHALL apply reset immediately and asynchronously, including mid-transaction; after release the block SHALL wait in IDLE for a sel_ high-to-low transition.

Verification
REQ-030 Write with auto-increment: sel_=0, bytes 0x42,0x11,0x22,0x33 -> reg2=0x11, reg3=0x22, reg4=0x33; three wr_stb pulses with wr_addr 2,3,4.
REQ-031 Read with auto-increment wrap: regs preloaded 6=0x66, status_in=0x5C, reg0=0x10; bytes 0xC6,x,x -> tx_byte 0x66 one cycle after the CMD byte, then 0x5C, then 0x10.
REQ-032 Write to address 7: bytes 0x07,0xFF -> no register change, wr_stb stays 0.
REQ-033 Abort: sel_ rises after 0x41 only -> busy=0 next cycle, reg1 unchanged; next transaction decodes its first byte as a command.
REQ-034 rx_valid together with sel_ rising in WDATA -> byte ignored, no write.
REQ-035 reset_ low mid-write -> all outputs return to reset values immediately; reg_q=0.
